// File: rtl/ssd_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_mux_pkg
//  Description : Shared digit codes, active-high segment glyphs, digit
//                indices and scan-state encodings for the display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package ssd_scan_mux_pkg;

   // Internal digit codes: 0-9 are decimal values, plus dash and blank.
   localparam logic [3:0] c_CODE_DASH  = 4'hA;
   localparam logic [3:0] c_CODE_BLANK = 4'hF;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] c_SEG_0     = 7'h3F;
   localparam logic [6:0] c_SEG_1     = 7'h06;
   localparam logic [6:0] c_SEG_2     = 7'h5B;
   localparam logic [6:0] c_SEG_3     = 7'h4F;
   localparam logic [6:0] c_SEG_4     = 7'h66;
   localparam logic [6:0] c_SEG_5     = 7'h6D;
   localparam logic [6:0] c_SEG_6     = 7'h7D;
   localparam logic [6:0] c_SEG_7     = 7'h07;
   localparam logic [6:0] c_SEG_8     = 7'h7F;
   localparam logic [6:0] c_SEG_9     = 7'h6F;
   localparam logic [6:0] c_SEG_DASH  = 7'h40;
   localparam logic [6:0] c_SEG_BLANK = 7'h00;

   // Digit positions, left (real sign) to right (imag magnitude).
   localparam logic [1:0] c_DIG_D3 = 2'd3;
   localparam logic [1:0] c_DIG_D2 = 2'd2;
   localparam logic [1:0] c_DIG_D1 = 2'd1;
   localparam logic [1:0] c_DIG_D0 = 2'd0;

   // Scan states; the low two bits are the digit index. START is the dark
   // state after reset, which also sits on digit 3.
   localparam logic [2:0] c_ST_D0    = 3'b000;
   localparam logic [2:0] c_ST_D1    = 3'b001;
   localparam logic [2:0] c_ST_D2    = 3'b010;
   localparam logic [2:0] c_ST_D3    = 3'b011;
   localparam logic [2:0] c_ST_START = 3'b111;

   // Sign digit: dash for a negative value, blank otherwise.
   function automatic logic [3:0] sign_code(input logic i_neg);
      return i_neg ? c_CODE_DASH : c_CODE_BLANK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_digit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_digit_decode
//  Description : Combinational digit code to active-high segment decoder.
//                Codes without a glyph decode to blank.
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_digit_decode
   import ssd_scan_mux_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   // Look up the glyph for the requested code.
   always_comb begin
      o_seg = c_SEG_BLANK;
      case (i_code)
         4'd0:        o_seg = c_SEG_0;
         4'd1:        o_seg = c_SEG_1;
         4'd2:        o_seg = c_SEG_2;
         4'd3:        o_seg = c_SEG_3;
         4'd4:        o_seg = c_SEG_4;
         4'd5:        o_seg = c_SEG_5;
         4'd6:        o_seg = c_SEG_6;
         4'd7:        o_seg = c_SEG_7;
         4'd8:        o_seg = c_SEG_8;
         4'd9:        o_seg = c_SEG_9;
         c_CODE_DASH: o_seg = c_SEG_DASH;
         default:     o_seg = c_SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_mux
//  Description : 4-digit common-anode seven-segment scanner for the complex
//                adder result (real sign, |real|, imag sign, |imag|), with a
//                frame-boundary double buffer and overflow blink.
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_scan_mux
   import ssd_scan_mux_pkg::*;
#(
   parameter int W            = 4,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter bit SEP_DP       = 1'b1,
   parameter int BLINK_FRAMES = 8
) (
   input  logic         clock_in,
   input  logic         reset_n,
   input  logic         scan_clk,
   input  logic         load,
   input  logic [W-1:0] real_in,
   input  logic [W-1:0] imag_in,
   input  logic         ovf_in,
   output logic [3:0]   an_out,
   output logic [6:0]   seg_out,
   output logic         dp_out,
   output logic         pending
);

   localparam int              c_CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(BLINK_FRAMES - 1);
   localparam logic [3:0]      c_AN_OFF   = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0]      c_SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic            c_DP_OFF   = ACTIVE_LOW;

   logic            r_scan_q;
   logic            w_tick;
   logic            w_commit;
   logic [2:0]      r_state;
   logic [2:0]      w_state_nxt;
   logic [W-1:0]    r_sh_re;
   logic [W-1:0]    r_sh_im;
   logic            r_sh_ovf;
   logic            r_pend;
   logic [W-1:0]    r_disp_re;
   logic [W-1:0]    r_disp_im;
   logic            r_disp_ovf;
   logic [W-1:0]    w_disp_re_nxt;
   logic [W-1:0]    w_disp_im_nxt;
   logic            w_disp_ovf_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic            r_hidden;
   logic            w_hidden_nxt;
   logic [1:0]      w_idx;
   logic [3:0]      w_code;
   logic [6:0]      w_seg_hi;
   logic [6:0]      w_seg_nxt;
   logic            w_dp_nxt;
   logic [3:0]      w_onehot;
   logic [3:0]      w_an_nxt;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp;

   // Magnitude of a two's complement value, one bit wider so -2^(W-1) fits.
   function automatic logic [W:0] abs_val(input logic [W-1:0] i_x);
      logic [W:0] v_ext;
      v_ext = {i_x[W-1], i_x};
      return i_x[W-1] ? (~v_ext + 1'b1) : v_ext;
   endfunction

   // A scan tick is the first clock_in cycle that sees scan_clk high.
   assign w_tick   = scan_clk & ~r_scan_q;
   assign w_commit = w_tick && (r_state == c_ST_D0);

   // Edge-detect register for the divided scan clock.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) r_scan_q <= 1'b0;
      else          r_scan_q <= scan_clk;
   end

   // Scan state register.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) r_state <= c_ST_START;
      else          r_state <= w_state_nxt;
   end

   // Next scan state: first tick after reset lights D3, then D3..D0 round robin.
   always_comb begin
      w_state_nxt = r_state;
      if (w_tick) begin
         case (r_state)
            c_ST_START: w_state_nxt = c_ST_D3;
            c_ST_D3:    w_state_nxt = c_ST_D2;
            c_ST_D2:    w_state_nxt = c_ST_D1;
            c_ST_D1:    w_state_nxt = c_ST_D0;
            c_ST_D0:    w_state_nxt = c_ST_D3;
            default:    w_state_nxt = c_ST_START;
         endcase
      end
   end

   // Display contents for the next cycle; a load coinciding with the frame
   // boundary bypasses the shadow so it is never lost.
   always_comb begin
      w_disp_re_nxt  = r_disp_re;
      w_disp_im_nxt  = r_disp_im;
      w_disp_ovf_nxt = r_disp_ovf;
      if (w_commit) begin
         if (load) begin
            w_disp_re_nxt  = real_in;
            w_disp_im_nxt  = imag_in;
            w_disp_ovf_nxt = ovf_in;
         end else if (r_pend) begin
            w_disp_re_nxt  = r_sh_re;
            w_disp_im_nxt  = r_sh_im;
            w_disp_ovf_nxt = r_sh_ovf;
         end
      end
   end

   // Blink phase: counts frames that keep overflow displayed; any frame
   // without a continuing overflow restarts the count in the visible phase.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_hidden_nxt = r_hidden;
      if (w_commit) begin
         if (!(r_disp_ovf && w_disp_ovf_nxt)) begin
            w_cnt_nxt    = '0;
            w_hidden_nxt = 1'b0;
         end else if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt    = '0;
            w_hidden_nxt = ~r_hidden;
         end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
         end
      end
   end

   // Shadow capture, commit of the display registers and pending flag.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_sh_re    <= '0;
         r_sh_im    <= '0;
         r_sh_ovf   <= 1'b0;
         r_pend     <= 1'b0;
         r_disp_re  <= '0;
         r_disp_im  <= '0;
         r_disp_ovf <= 1'b0;
         r_cnt      <= '0;
         r_hidden   <= 1'b0;
      end else begin
         if (load) begin
            r_sh_re  <= real_in;
            r_sh_im  <= imag_in;
            r_sh_ovf <= ovf_in;
         end
         if (w_commit)  r_pend <= 1'b0;
         else if (load) r_pend <= 1'b1;
         r_disp_re  <= w_disp_re_nxt;
         r_disp_im  <= w_disp_im_nxt;
         r_disp_ovf <= w_disp_ovf_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hidden   <= w_hidden_nxt;
      end
   end

   // Select the digit code for the digit being entered.
   always_comb begin
      w_idx  = w_state_nxt[1:0];
      w_code = c_CODE_BLANK;
      case (w_idx)
         c_DIG_D3: w_code = sign_code(w_disp_re_nxt[W-1]);
         c_DIG_D2: w_code = 4'(abs_val(w_disp_re_nxt));
         c_DIG_D1: w_code = sign_code(w_disp_im_nxt[W-1]);
         default:  w_code = 4'(abs_val(w_disp_im_nxt));
      endcase
   end

   ssd_digit_decode u_decode (
      .i_code (w_code),
      .o_seg  (w_seg_hi)
   );

   // Apply output polarity, decimal-point separator and blink blanking.
   always_comb begin
      w_seg_nxt = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
      w_dp_nxt  = (SEP_DP && (w_idx == c_DIG_D2)) ^ ACTIVE_LOW;
      w_onehot  = 4'b0001 << w_idx;
      w_an_nxt  = c_AN_OFF;
      if (!w_hidden_nxt) w_an_nxt = ACTIVE_LOW ? ~w_onehot : w_onehot;
   end

   // Output registers load on each tick and hold until the next one.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_an  <= c_AN_OFF;
         r_seg <= c_SEG_OFF;
         r_dp  <= c_DP_OFF;
      end else if (w_tick) begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   // Anodes are dark during the tick cycle so the old digit never shows new segments.
   assign an_out  = w_tick ? c_AN_OFF : r_an;
   assign seg_out = r_seg;
   assign dp_out  = r_dp;
   assign pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_scan_mux
//  Description : Self-checking bench for ssd_scan_mux (active-low outputs,
//                separator dp, two-frame blink) against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ssd_scan_mux;

   localparam int BF = 2;

   logic       clock_in = 1'b0;
   logic       reset_n;
   logic       scan_clk;
   logic       load;
   logic [3:0] real_in;
   logic [3:0] imag_in;
   logic       ovf_in;
   logic [3:0] an_out;
   logic [6:0] seg_out;
   logic       dp_out;
   logic       pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of what the display should be showing.
   int         m_pos;
   int         m_re, m_im, m_sh_re, m_sh_im;
   bit         m_ovf, m_sh_ovf, m_pend;
   int         m_k;
   logic [3:0] an_at_tick;

   ssd_scan_mux #(
      .W            (4),
      .ACTIVE_LOW   (1'b1),
      .SEP_DP       (1'b1),
      .BLINK_FRAMES (BF)
   ) dut (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .scan_clk (scan_clk),
      .load     (load),
      .real_in  (real_in),
      .imag_in  (imag_in),
      .ovf_in   (ovf_in),
      .an_out   (an_out),
      .seg_out  (seg_out),
      .dp_out   (dp_out),
      .pending  (pending)
   );

   always #5 clock_in = ~clock_in;

   // Active-low glyphs {g,f,e,d,c,b,a}: 0..9, 10 = dash, anything else blank.
   function automatic logic [6:0] glyph(input int ch);
      case (ch)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         10: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected {an, seg, dp, pending} for the digit the model says is shown.
   function automatic logic [12:0] exp_vec();
      int         ch;
      bit         vis;
      logic [3:0] an;
      if (m_pos < 0) return {4'hF, 7'h7F, 1'b1, m_pend};
      case (m_pos)
         3:       ch = (m_re < 0) ? 10 : 11;
         2:       ch = (m_re < 0) ? -m_re : m_re;
         1:       ch = (m_im < 0) ? 10 : 11;
         default: ch = (m_im < 0) ? -m_im : m_im;
      endcase
      vis = !m_ovf || (((m_k / BF) % 2) == 0);
      an  = vis ? ~(4'(1) << m_pos) : 4'hF;
      return {an, glyph(ch), (m_pos == 2) ? 1'b0 : 1'b1, m_pend};
   endfunction

   task automatic model_reset();
      m_pos = -1; m_re = 0; m_im = 0; m_ovf = 0;
      m_sh_re = 0; m_sh_im = 0; m_sh_ovf = 0; m_pend = 0; m_k = 0;
   endtask

   task automatic model_tick(input bit ld, input int re, input int im, input bit ov);
      bit old_ovf;
      if (m_pos == 0) begin
         old_ovf = m_ovf;
         if (ld) begin
            m_re = re; m_im = im; m_ovf = ov;
         end else if (m_pend) begin
            m_re = m_sh_re; m_im = m_sh_im; m_ovf = m_sh_ovf;
         end
         if (ld) begin m_sh_re = re; m_sh_im = im; m_sh_ovf = ov; end
         m_pend = 0;
         m_k    = (old_ovf && m_ovf) ? m_k + 1 : 0;
         m_pos  = 3;
      end else begin
         m_pos = (m_pos < 0) ? 3 : m_pos - 1;
         if (ld) begin m_sh_re = re; m_sh_im = im; m_sh_ovf = ov; m_pend = 1; end
      end
   endtask

   // One scan tick, optionally with a coincident load. Starts and ends on a
   // falling clock edge, leaving scan_clk high.
   task automatic drive_tick(input bit ld, input int re, input int im, input bit ov);
      if (scan_clk) begin
         scan_clk = 1'b0;
         @(negedge clock_in);
      end
      scan_clk = 1'b1;
      load     = ld;
      real_in  = 4'(re);
      imag_in  = 4'(im);
      ovf_in   = ov;
      #1 an_at_tick = an_out;
      @(posedge clock_in);
      #1 load = 1'b0;
      model_tick(ld, re, im, ov);
      @(negedge clock_in);
   endtask

   // A load outside any tick cycle.
   task automatic do_load(input int re, input int im, input bit ov);
      load    = 1'b1;
      real_in = 4'(re);
      imag_in = 4'(im);
      ovf_in  = ov;
      @(posedge clock_in);
      #1 load = 1'b0;
      m_sh_re = re; m_sh_im = im; m_sh_ovf = ov; m_pend = 1;
      @(negedge clock_in);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; scan_clk = 1'b0; load = 1'b0;
      real_in = '0; imag_in = '0; ovf_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clock_in);
      n_checks++;
      if ({an_out, seg_out, dp_out, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got %b %b %b %b, expected 1111 1111111 1 0",
                  an_out, seg_out, dp_out, pending);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clock_in);
      n_checks++;
      if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_release_dark: got %b %b %b %b, expected %b",
                  an_out, seg_out, dp_out, pending, exp_vec());
      end
   endtask

   task automatic test_blank_frame();
      for (int i = 0; i < 4; i++) begin
         drive_tick(1'b0, 0, 0, 1'b0);
         n_checks++;
         if (an_at_tick !== 4'hF) begin
            n_fail++;
            $display("FAIL blank_antighost[%0d]: got an=%b, expected 1111", i, an_at_tick);
         end
         n_checks++;
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL blank_frame[%0d]: got %b %b %b %b, expected %b",
                     i, an_out, seg_out, dp_out, pending, exp_vec());
         end
      end
   endtask

   task automatic test_load_commit();
      do_load(-3, 5, 1'b0);
      n_checks++;
      if (pending !== 1'b1) begin
         n_fail++;
         $display("FAIL load_sets_pending: got %b, expected 1", pending);
      end
      for (int i = 0; i < 4; i++) begin
         drive_tick(1'b0, 0, 0, 1'b0);
         n_checks++;
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_commit[%0d]: got %b %b %b %b, expected %b",
                     i, an_out, seg_out, dp_out, pending, exp_vec());
         end
      end
   endtask

   task automatic test_mid_frame_load();
      for (int i = 0; i < 8; i++) begin
         drive_tick(1'b0, 0, 0, 1'b0);
         if (i == 1) do_load(-8, 5, 1'b0);
         n_checks++;
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_frame_load[%0d]: got %b %b %b %b, expected %b",
                     i, an_out, seg_out, dp_out, pending, exp_vec());
         end
      end
   endtask

   task automatic test_last_wins();
      for (int i = 0; i < 8; i++) begin
         drive_tick(i == 4, 4, 4, 1'b0);
         if (i == 0) begin
            do_load(2, 2, 1'b0);
            do_load(7, -7, 1'b0);
         end
         n_checks++;
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL last_wins_coincident[%0d]: got %b %b %b %b, expected %b",
                     i, an_out, seg_out, dp_out, pending, exp_vec());
         end
      end
   endtask

   task automatic test_blink();
      do_load(1, -1, 1'b1);
      for (int i = 0; i < 36; i++) begin
         if (i == 28) do_load(1, -1, 1'b0);
         drive_tick(1'b0, 0, 0, 1'b0);
         n_checks++;
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL blink[%0d]: got %b %b %b %b, expected %b",
                     i, an_out, seg_out, dp_out, pending, exp_vec());
         end
      end
   endtask

   task automatic test_hold_high();
      int bad = 0;
      drive_tick(1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock_in);
         if ({an_out, seg_out, dp_out, pending} !== exp_vec()) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_high: %0d cycles deviated, last got %b %b %b %b, expected %b",
                  bad, an_out, seg_out, dp_out, pending, exp_vec());
      end
      drive_tick(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (an_at_tick !== 4'hF || {an_out, seg_out, dp_out, pending} !== exp_vec()) begin
         n_fail++;
         $display("FAIL hold_release_tick: tick an=%b, got %b %b %b %b, expected %b",
                  an_at_tick, an_out, seg_out, dp_out, pending, exp_vec());
      end
   endtask

   task automatic test_reset_mid_frame();
      while (m_pos != 1) drive_tick(1'b0, 0, 0, 1'b0);
      do_load(6, 6, 1'b0);
      scan_clk = 1'b0;
      reset_n  = 1'b0;
      #1;
      n_checks++;
      if ({an_out, seg_out, dp_out, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_d1: got %b %b %b %b, expected 1111 1111111 1 0",
                  an_out, seg_out, dp_out, pending);
      end
      model_reset();
      @(negedge clock_in);
      reset_n = 1'b1;
      @(negedge clock_in);
      drive_tick(1'b0, 0, 0, 1'b0);
      n_checks++;
      if ({an_out, seg_out, dp_out, pending} !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_restart_d3: got %b %b %b %b, expected %b",
                  an_out, seg_out, dp_out, pending, exp_vec());
      end
   endtask

   task automatic test_random();
      int re, im;
      bit ov;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(3) == 0) begin
            re = int'($urandom_range(15)) - 8;
            im = int'($urandom_range(15)) - 8;
            do_load(re, im, $urandom_range(2) == 0);
         end
         re = int'($urandom_range(15)) - 8;
         im = int'($urandom_range(15)) - 8;
         ov = ($urandom_range(2) == 0);
         drive_tick($urandom_range(4) == 0, re, im, ov);
         n_checks++;
         if (an_at_tick !== 4'hF || {an_out, seg_out, dp_out, pending} !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: tick an=%b, got %b %b %b %b, expected %b",
                     i, an_at_tick, an_out, seg_out, dp_out, pending, exp_vec());
         end
         repeat ($urandom_range(2)) @(negedge clock_in);
      end
   endtask

   initial begin
      test_reset();
      test_blank_frame();
      test_load_commit();
      test_mid_frame_load();
      test_last_wins();
      test_blink();
      test_hold_high();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
